// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encodings and small decode helpers.
package mdu_iter_pkg;

  localparam int MDU_WIDTH = 32;

  // MDU operation codes carried on the op port alongside start
  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  // True for the four ops that run through the multi-cycle datapath
  function automatic logic is_muldiv(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  // True for the ops whose operands are two's complement
  function automatic logic is_signed_op(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  // True for the divide ops
  function automatic logic is_div_op(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration of the shared multiply/divide datapath.
// The 2*WIDTH accumulator holds {partial product, multiplier} when
// multiplying and {partial remainder, dividend/quotient} when dividing.
module mdu_iter_step
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;

  // Multiplicand gated by the current multiplier LSB
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_gate
      assign addend[gi] = operand[gi] & acc[0];
    end
  endgenerate

  // Mul: add then shift right keeping the carry; div: restoring trial subtract
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, operand};
    acc_next  = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      // The partial remainder stays below the divisor, so the trial result
      // always fits in WIDTH bits when its sign bit is clear.
      if (!div_trial[WIDTH]) begin
        acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Runs one radix-2 step per cycle on magnitudes, then applies sign
// correction in a final fix-up cycle before writing HI/LO.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER + 1);

  mdu_state_e         state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   operand_reg;
  logic               is_div_reg;
  logic               neg_main_reg;
  logic               neg_rem_reg;
  logic               bzero_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               done_reg;

  mdu_op_e            op_e;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi_next;
  logic [WIDTH-1:0]   fix_lo_next;

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_reg),
    .acc      (acc_reg),
    .operand  (operand_reg),
    .acc_next (acc_next)
  );

  // Operand decode: magnitudes and sign flags for signed ops
  always_comb begin
    op_e  = mdu_op_e'(op);
    a_neg = is_signed_op(op_e) & a[WIDTH-1];
    b_neg = is_signed_op(op_e) & b[WIDTH-1];
    a_abs = a_neg ? -a : a;
    b_abs = b_neg ? -b : b;
  end

  // Sign fix-up of the finished magnitude result
  always_comb begin
    prod_fix = neg_main_reg ? -acc_reg : acc_reg;
    quo_fix  = neg_main_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem_fix  = neg_rem_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    // A zero divisor yields an all-ones quotient regardless of signs; the
    // remainder already equals the dividend after sign restoration.
    if (bzero_reg) begin
      quo_fix = '1;
    end
    if (is_div_reg) begin
      fix_hi_next = rem_fix;
      fix_lo_next = quo_fix;
    end else begin
      fix_hi_next = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo_next = prod_fix[WIDTH-1:0];
    end
  end

  // Sequencer, iteration counter, scratch and HI/LO registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      operand_reg  <= '0;
      is_div_reg   <= 1'b0;
      neg_main_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
      bzero_reg    <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // A squash in the same cycle drops the request entirely
          if (start && !flush) begin
            if (is_muldiv(op_e)) begin
              state_reg    <= ST_CALC;
              cnt_reg      <= '0;
              is_div_reg   <= is_div_op(op_e);
              neg_main_reg <= a_neg ^ b_neg;
              neg_rem_reg  <= a_neg;
              bzero_reg    <= is_div_op(op_e) && (b == '0);
              if (is_div_op(op_e)) begin
                acc_reg     <= {{WIDTH{1'b0}}, a_abs};
                operand_reg <= b_abs;
              end else begin
                acc_reg     <= {{WIDTH{1'b0}}, b_abs};
                operand_reg <= a_abs;
              end
            end else if (op_e == MDU_MTHI) begin
              hi_reg <= a;
            end else if (op_e == MDU_MTLO) begin
              lo_reg <= a;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            state_reg <= ST_IDLE;
          end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + CW'(1);
            if (cnt_reg == CW'(ITER - 1)) begin
              state_reg <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          state_reg <= ST_IDLE;
          if (!flush) begin
            hi_reg   <= fix_hi_next;
            lo_reg   <= fix_lo_next;
            done_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_reg != ST_IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases, randomized mul/div
// against an arithmetic reference, busy/flush/reset interactions.
module tb_mdu_iter;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam int LAT = 33;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32), .ITER(32)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Reference result {hi, lo} from plain integer arithmetic
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy, q, r;
    logic [31:0] uq, ur;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p = '0;
    case (o)
      OP_MULT:  begin q = sx * sy; p = q; end
      OP_MULTU: p = {32'b0, x} * {32'b0, y};
      OP_DIV: begin
        if (y == 0) p = {x, 32'hFFFFFFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (y == 0) p = {x, 32'hFFFFFFFF};
        else begin
          uq = x / y;
          ur = x % y;
          p = {ur, uq};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Launch an op at the current negedge and wait (bounded) for done
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] h, output logic [31:0] l,
                        output int lat, output bit busy_ok);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = -1; busy_ok = 1'b1; h = 'x; l = 'x;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        lat = k; h = hi; l = lo;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  // Load HI and LO through MTHI/MTLO
  task automatic load_hilo(input logic [31:0] h, input logic [31:0] l);
    start = 1'b1; op = OP_MTHI; a = h; b = '0;
    @(negedge clk);
    op = OP_MTLO; a = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Start MULTU 7*6, abort at cycle at_k by flush or reset, observe aftermath
  task automatic abort_run(input int at_k, input bit use_rst, output logic busy_after,
                           output bit saw_done);
    start = 1'b1; op = OP_MULTU; a = 32'd7; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < at_k; k++) @(negedge clk);
    if (use_rst) rstn = 1'b0; else flush = 1'b1;
    @(negedge clk);
    rstn = 1'b1; flush = 1'b0;
    busy_after = busy;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; flush = 1'b0; op = OP_NOP; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [2:0]  ops [6] = '{OP_MULTU, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIV};
    logic [31:0] as  [6] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000};
    logic [31:0] bs  [6] = '{32'd6, 32'd2, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFF};
    logic [63:0] exp [6] = '{64'h0000_0000_0000_002A, 64'hFFFF_FFFF_FFFF_FFFE,
                             64'h0000_0001_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD,
                             64'h0000_0007_FFFF_FFFF, 64'h0000_0000_8000_0000};
    logic [31:0] h, l;
    int lat;
    bit bok;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], h, l, lat, bok);
      $display("directed op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", ops[i], as[i], bs[i], h, l, lat);
      checks++; if ({h, l} !== exp[i]) begin failures++;
        $display("FAIL directed_%0d_hilo got=%h exp=%h", i, {h, l}, exp[i]); end
      checks++; if (lat != LAT) begin failures++;
        $display("FAIL directed_%0d_latency got=%0d exp=%0d", i, lat, LAT); end
      checks++; if (!bok) begin failures++;
        $display("FAIL directed_%0d_busy got=0 exp=1 while in flight", i); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++;
        $display("FAIL directed_%0d_done_pulse got=%b exp=0", i, done); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y, h, l;
    logic [63:0] e;
    int lat;
    bit bok;
    for (int i = 0; i < 40; i++) begin
      o = 3'(1 + $urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: y = 32'($urandom_range(1, 15));
        2: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        3: x = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      e = ref_result(o, x, y);
      run_op(o, x, y, h, l, lat, bok);
      $display("random op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", o, x, y, h, l, lat);
      checks++; if ({h, l} !== e || lat != LAT || !bok) begin failures++;
        $display("FAIL random_%0d op=%0d a=%h b=%h got=%h lat=%0d busy_ok=%0d exp=%h lat=%0d",
                 i, o, x, y, {h, l}, lat, bok, e, LAT); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] h, l;
    int lat;
    bit bok;
    start = 1'b1; op = OP_MULTU; a = 32'd7; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      if (done) begin lat = k; break; end
      if (k == 5) begin start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd3; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    $display("busy_start multu 7*6 -> hi=%h lo=%h lat=%0d", hi, lo, lat);
    checks++; if (lat != LAT) begin failures++;
      $display("FAIL ignore_busy_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (lo !== 32'd42 || hi !== 32'd0) begin failures++;
      $display("FAIL ignore_busy_result got=%h_%h exp=00000000_0000002a", hi, lo); end
    // Issued in the done cycle
    run_op(OP_DIVU, 32'd100, 32'd3, h, l, lat, bok);
    $display("done_cycle divu 100/3 -> hi=%h lo=%h lat=%0d", h, l, lat);
    checks++; if (l !== 32'd33 || h !== 32'd1) begin failures++;
      $display("FAIL done_cycle_start got=%h_%h exp=00000001_00000021", h, l); end
    checks++; if (lat != LAT || !bok) begin failures++;
      $display("FAIL done_cycle_latency got=%0d busy_ok=%0d exp=%0d", lat, bok, LAT); end
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo();
    bit saw_done;
    saw_done = 1'b0;
    start = 1'b1; op = OP_MTHI; a = 32'h1234;
    @(negedge clk);
    if (done) saw_done = 1'b1;
    $display("mthi a=00001234 -> hi=%h busy=%b", hi, busy);
    checks++; if (hi !== 32'h1234 || busy !== 1'b0) begin failures++;
      $display("FAIL mthi got hi=%h busy=%b exp hi=00001234 busy=0", hi, busy); end
    op = OP_MTLO; a = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    if (done) saw_done = 1'b1;
    $display("mtlo a=00005678 -> lo=%h hi=%h busy=%b", lo, hi, busy);
    checks++; if (lo !== 32'h5678 || hi !== 32'h1234 || busy !== 1'b0) begin failures++;
      $display("FAIL mtlo got hi=%h lo=%h busy=%b exp 00001234 00005678 0", hi, lo, busy); end
    // NOP and an undefined op must be ignored
    start = 1'b1; op = OP_NOP; a = 32'hDEAD;
    @(negedge clk);
    if (done) saw_done = 1'b1;
    op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    if (done) saw_done = 1'b1;
    checks++; if (hi !== 32'h1234 || lo !== 32'h5678 || busy !== 1'b0) begin failures++;
      $display("FAIL nop_undef got hi=%h lo=%h busy=%b exp 00001234 00005678 0", hi, lo, busy); end
    checks++; if (saw_done) begin failures++;
      $display("FAIL mthi_mtlo_done got=1 exp=0"); end
  endtask

  task automatic test_flush();
    logic busy_after;
    bit saw_done;
    int ks [2] = '{10, 32};
    for (int i = 0; i < 2; i++) begin
      load_hilo(32'h1234, 32'h5678);
      abort_run(ks[i], 1'b0, busy_after, saw_done);
      $display("flush at cycle %0d -> busy=%b done_seen=%0d hi=%h lo=%h", ks[i], busy_after, saw_done, hi, lo);
      checks++; if (busy_after !== 1'b0 || saw_done) begin failures++;
        $display("FAIL flush_%0d got busy=%b done=%0d exp busy=0 done=0", ks[i], busy_after, saw_done); end
      checks++; if (hi !== 32'h1234 || lo !== 32'h5678) begin failures++;
        $display("FAIL flush_%0d_hilo got=%h_%h exp=00001234_00005678", ks[i], hi, lo); end
    end
    // flush together with start in IDLE drops the op
    start = 1'b1; flush = 1'b1; op = OP_MTHI; a = 32'hDEAD;
    @(negedge clk);
    op = OP_MULTU; a = 32'd7; b = 32'd6;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++; if (hi !== 32'h1234 || busy !== 1'b0) begin failures++;
      $display("FAIL flush_start got hi=%h busy=%b exp hi=00001234 busy=0", hi, busy); end
  endtask

  task automatic test_reset_abort();
    logic busy_after;
    bit saw_done;
    load_hilo(32'h1234, 32'h5678);
    abort_run(10, 1'b1, busy_after, saw_done);
    $display("reset at cycle 10 -> busy=%b done_seen=%0d hi=%h lo=%h", busy_after, saw_done, hi, lo);
    checks++; if (busy_after !== 1'b0 || saw_done) begin failures++;
      $display("FAIL reset_abort got busy=%b done=%0d exp busy=0 done=0", busy_after, saw_done); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++;
      $display("FAIL reset_abort_hilo got=%h_%h exp=00000000_00000000", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mthi_mtlo();
    test_flush();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
